// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline controller: state encodings and drain timeout default.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int DRAIN_TIMEOUT_DEF = 8;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline run/step/drain/halt controller producing global pipeline and PC enables,
// plus a saturating count of enabled cycles and a sticky drain-timeout flag.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_id_halt,
    input  logic             i_wb_halt,
    output logic             o_pipe_en,
    output logic             o_pc_en,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic             o_step_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_count
);

    // Drain counter only has to reach DRAIN_TIMEOUT-1.
    localparam int DW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          timeout_set;
    logic          step_done_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign o_state   = state;
    assign o_pipe_en = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
    assign o_pc_en   = (state == ST_RUN) || (state == ST_STEP);
    assign o_halted  = (state == ST_HALTED);

    always_comb begin
        state_nxt     = state;
        drain_nxt     = drain_cnt;
        timeout_set   = 1'b0;
        step_done_nxt = 1'b0;
        if (i_clear) begin
            state_nxt = ST_IDLE;
            drain_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start)     state_nxt = ST_RUN;
                    else if (i_step) state_nxt = ST_STEP;
                end
                ST_RUN: begin
                    if (i_wb_halt) begin
                        state_nxt = ST_HALTED;
                    end else if (i_id_halt) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = '0;
                    end
                end
                ST_STEP: begin
                    if (i_id_halt) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = '0;
                    end else if (i_wb_halt) begin
                        state_nxt = ST_HALTED;
                    end else begin
                        state_nxt     = ST_IDLE;
                        step_done_nxt = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (i_wb_halt) begin
                        state_nxt = ST_HALTED;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state_nxt   = ST_HALTED;
                        timeout_set = 1'b1;
                    end else begin
                        drain_nxt = drain_cnt + DW'(1);
                    end
                end
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            o_step_done   <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_nxt;
            o_step_done <= step_done_nxt;
            if (i_clear)          o_timeout <= 1'b0;
            else if (timeout_set) o_timeout <= 1'b1;
            if (i_clear)          o_cycle_count <= '0;
            else if (o_pipe_en)   o_cycle_count <= sat_inc(o_cycle_count);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a spec-level model checked every cycle on two
// instances (32-bit and 4-bit counters) plus literal checkpoints per scenario.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_start = 1'b0, i_step = 1'b0, i_clear = 1'b0, i_id_halt = 1'b0, i_wb_halt = 1'b0;

    logic        a_pipe_en, a_pc_en, a_halted, a_step_done, a_timeout;
    logic [2:0]  a_state;
    logic [31:0] a_count;
    logic        b_pipe_en, b_pc_en, b_halted, b_step_done, b_timeout;
    logic [2:0]  b_state;
    logic [3:0]  b_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32), .DRAIN_TIMEOUT(8)) dut32 (
        .clk(clk), .reset(reset), .i_start(i_start), .i_step(i_step), .i_clear(i_clear),
        .i_id_halt(i_id_halt), .i_wb_halt(i_wb_halt), .o_pipe_en(a_pipe_en), .o_pc_en(a_pc_en),
        .o_state(a_state), .o_halted(a_halted), .o_step_done(a_step_done),
        .o_timeout(a_timeout), .o_cycle_count(a_count)
    );

    pipeline_ctrl #(.CNT_W(4), .DRAIN_TIMEOUT(8)) dut4 (
        .clk(clk), .reset(reset), .i_start(i_start), .i_step(i_step), .i_clear(i_clear),
        .i_id_halt(i_id_halt), .i_wb_halt(i_wb_halt), .o_pipe_en(b_pipe_en), .o_pc_en(b_pc_en),
        .o_state(b_state), .o_halted(b_halted), .o_step_done(b_step_done),
        .o_timeout(b_timeout), .o_cycle_count(b_count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: state names as plain ints, counts as saturating integers.
    int     m_state = 0;
    int     m_drain = 0;
    bit     m_timeout = 0;
    bit     m_step_done = 0;
    longint m_cnt32 = 0;
    longint m_cnt4 = 0;
    bit     checking = 0;

    function automatic bit m_enabled(input int s);
        return s == 1 || s == 2 || s == 3;
    endfunction

    always @(posedge clk) begin
        if (reset || i_clear) begin
            m_state = 0; m_drain = 0; m_timeout = 0; m_step_done = 0;
            m_cnt32 = 0; m_cnt4 = 0;
        end else begin
            if (m_enabled(m_state)) begin
                m_cnt32 = (m_cnt32 == 64'hFFFF_FFFF) ? m_cnt32 : m_cnt32 + 1;
                m_cnt4  = (m_cnt4 == 15) ? m_cnt4 : m_cnt4 + 1;
            end
            m_step_done = 0;
            if (m_state == 0) begin
                if (i_start) m_state = 1;
                else if (i_step) m_state = 2;
            end else if (m_state == 1) begin
                if (i_wb_halt) m_state = 4;
                else if (i_id_halt) begin m_state = 3; m_drain = 0; end
            end else if (m_state == 2) begin
                if (i_id_halt) begin m_state = 3; m_drain = 0; end
                else if (i_wb_halt) m_state = 4;
                else begin m_state = 0; m_step_done = 1; end
            end else if (m_state == 3) begin
                if (i_wb_halt) m_state = 4;
                else if (m_drain == 8 - 1) begin m_state = 4; m_timeout = 1; end
                else m_drain++;
            end
        end
    end

    int n_pe = 0, n_sd = 0, n_drain = 0;

    always @(negedge clk) begin
        if (checking) begin
            check("state", a_state, m_state);
            check("pipe_en", a_pipe_en, m_enabled(m_state));
            check("pc_en", a_pc_en, (m_state == 1 || m_state == 2));
            check("halted", a_halted, (m_state == 4));
            check("step_done", a_step_done, m_step_done);
            check("timeout", a_timeout, m_timeout);
            check("count32", a_count, m_cnt32);
            check("count4", b_count, m_cnt4);
            check("state4", b_state, m_state);
            if (a_pipe_en) n_pe++;
            if (a_step_done) n_sd++;
            if (a_state == 3) n_drain++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        n_pe = 0; n_sd = 0; n_drain = 0;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        checking = 1'b1;
        check("reset_state", a_state, 0);
        check("reset_count", a_count, 0);
        check("reset_pipe_en", a_pipe_en, 0);

        // Start pulse, 10 plain RUN cycles, then WB halt.
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(10);
        i_wb_halt = 1'b1; tick(); i_wb_halt = 1'b0;
        check("run_halted", a_halted, 1);
        check("run_count", a_count, 11);
        check("run_pc_en", a_pc_en, 0);
        i_start = 1'b1; i_step = 1'b1; i_id_halt = 1'b1; tick(2);
        i_start = 1'b0; i_step = 1'b0; i_id_halt = 1'b0;
        check("halted_ignores", a_state, 4);

        // Three isolated step pulses.
        do_clear();
        for (int k = 0; k < 3; k++) begin
            i_step = 1'b1; tick(); i_step = 1'b0;
            tick(3);
        end
        check("step_pe_pulses", n_pe, 3);
        check("step_done_pulses", n_sd, 3);
        check("step_count", a_count, 3);

        // ID halt on RUN cycle 5, WB halt three cycles later.
        do_clear();
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(4);
        i_id_halt = 1'b1; tick(); i_id_halt = 1'b0;
        check("drain_entry_state", a_state, 3);
        check("drain_pc_en", a_pc_en, 0);
        check("drain_pipe_en", a_pipe_en, 1);
        i_step = 1'b1; tick(2); i_step = 1'b0;
        i_wb_halt = 1'b1; tick(); i_wb_halt = 1'b0;
        check("drain_halted", a_halted, 1);
        check("drain_timeout", a_timeout, 0);

        // Drain with no WB halt: forced halt after 8 DRAIN cycles.
        do_clear();
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(2);
        i_id_halt = 1'b1; tick(); i_id_halt = 1'b0;
        tick(7);
        check("to_still_drain", a_state, 3);
        tick();
        check("to_halted", a_halted, 1);
        check("to_drain_cycles", n_drain, 8);
        check("to_flag", a_timeout, 1);
        tick(3);
        check("to_sticky", a_timeout, 1);

        // Start and step together.
        do_clear();
        check("clear_timeout", a_timeout, 0);
        i_start = 1'b1; i_step = 1'b1; tick(); i_start = 1'b0; i_step = 1'b0;
        check("both_run", a_state, 1);
        tick(3);
        check("both_no_step_done", n_sd, 0);

        // Reset mid-RUN drops the enables in the following cycle.
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_pipe_en", a_pipe_en, 0);
        check("rst_pc_en", a_pc_en, 0);
        check("rst_count", a_count, 0);

        // 4-bit counter saturation over 20 RUN cycles, then clear.
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(20);
        check("sat_count4", b_count, 15);
        tick(3);
        check("sat_held4", b_count, 15);
        check("sat_count32", a_count, 23);
        do_clear();
        check("sat_clear_state", b_state, 0);
        check("sat_clear_count", b_count, 0);
        tick(2);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
